// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver (and the future uart_tx):
//   - uart_state_e : FSM state encoding (IDLE/START/DATA/PARITY/STOP/BREAK)
//   - DATA_BITS    : data bits per frame
//   - DEFAULT_CLOCK_DIV : clocks per bit period for 115200 baud at 100 MHz
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DATA_BITS         = 8;
    localparam logic [15:0] DEFAULT_CLOCK_DIV = 16'd868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchroniser for a single asynchronous bit. All flops reset to 1
// so an idle-high serial line does not look like a start bit after reset.
// Parameters:
//   STAGES : number of flops, 2..3
// Ports:
//   clock  : system clock
//   reset  : synchronous active-low reset
//   d      : asynchronous input
//   q      : synchronised output (last flop)
// -----------------------------------------------------------------------------
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2 || STAGES > 3) begin : g_stages_check
        $error("bit_synchronizer: STAGES must be 2..3");
    end

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] stage_in;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign stage_in[gi] = d;
        end else begin : g_chain
            assign stage_in[gi] = sync_reg[gi-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= stage_in;
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, with an
// optional parity bit (enable with macro UART_RX_PARITY_EN; PARITY_ODD then
// selects odd parity, default even). Received bytes are offered on a
// valid/ready handshake; frame_error and overrun are sticky until clear_errors.
// Parameters:
//   CLOCK_DIV   : clocks per bit period (>= 4)
//   SYNC_STAGES : synchroniser depth on rx (2..3)
//   PARITY_ODD  : (UART_RX_PARITY_EN only) 1 = odd parity, 0 = even parity
// Ports:
//   clock        : system clock
//   reset        : synchronous active-low reset
//   rx           : asynchronous serial input, idles high
//   data_out     : last received byte
//   data_valid   : data_out holds an unconsumed byte
//   data_ready   : consumer accepts the byte when data_valid && data_ready
//   clear_errors : pulse clearing frame_error and overrun
//   frame_error  : sticky, bad stop (or parity) bit seen
//   overrun      : sticky, a byte arrived while the previous one was unread
//   busy         : FSM not in IDLE
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_DIV   = DEFAULT_CLOCK_DIV,
    parameter int unsigned SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD  = 1'b0
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    input  logic       clear_errors,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    if (CLOCK_DIV < 4) begin : g_div_check
        $error("uart_rx: CLOCK_DIV must be >= 4");
    end

    // START waits half a bit so every later sample lands mid-bit.
    localparam logic [15:0] HALF_RELOAD = 16'((CLOCK_DIV >> 1) - 1);
    localparam logic [15:0] FULL_RELOAD = 16'(CLOCK_DIV - 1);

    logic rx_s;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_state_e          state_reg,       state_next;
    logic [15:0]          timer_reg,       timer_next;
    logic [2:0]           bit_cnt_reg,     bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,       shift_next;
    logic                 deliver_reg,     deliver_next;
    logic [DATA_BITS-1:0] data_out_reg,    data_out_next;
    logic                 data_valid_reg,  data_valid_next;
    logic                 frame_error_reg, frame_error_next;
    logic                 overrun_reg,     overrun_next;
    logic                 parity_bad_reg,  parity_bad_next;
    logic                 frame_set;
    logic                 overrun_set;
    logic                 timer_expired;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            deliver_reg     <= 1'b0;
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            parity_bad_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            deliver_reg     <= deliver_next;
            data_out_reg    <= data_out_next;
            data_valid_reg  <= data_valid_next;
            frame_error_reg <= frame_error_next;
            overrun_reg     <= overrun_next;
            parity_bad_reg  <= parity_bad_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        deliver_next    = 1'b0;
        parity_bad_next = parity_bad_reg;
        frame_set       = 1'b0;
        timer_expired   = (timer_reg == 16'd0);

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    timer_next = HALF_RELOAD;
                end
            end

            START: begin
                if (timer_expired) begin
                    if (rx_s) begin
                        // Line went back high before mid-bit: a glitch.
                        state_next = IDLE;
                    end else begin
                        state_next      = DATA;
                        timer_next      = FULL_RELOAD;
                        bit_cnt_next    = 3'd0;
                        parity_bad_next = 1'b0;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end

            DATA: begin
                if (timer_expired) begin
                    shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                    timer_next   = FULL_RELOAD;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer_expired) begin
                    timer_next = FULL_RELOAD;
                    state_next = STOP;
                    // Data XOR parity bit is 0 for even parity, 1 for odd.
                    if (((^shift_reg) ^ rx_s) != PARITY_ODD) begin
                        frame_set       = 1'b1;
                        parity_bad_next = 1'b1;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
`endif

            STOP: begin
                if (timer_expired) begin
                    if (rx_s) begin
                        deliver_next = !parity_bad_reg;
                        state_next   = IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end

            BREAK: begin
                // Hold here while the line is low so a break condition does
                // not spawn a stream of bogus frames.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output handshake: delivery is applied one edge after the stop sample.
    always_comb begin
        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        overrun_set     = 1'b0;

        if (deliver_reg) begin
            if (!data_valid_reg || data_ready) begin
                data_out_next   = shift_reg;
                data_valid_next = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (data_valid_reg && data_ready) begin
            data_valid_next = 1'b0;
        end

        // A set event on the same edge as clear_errors wins.
        frame_error_next = frame_set   | (frame_error_reg & ~clear_errors);
        overrun_next     = overrun_set | (overrun_reg     & ~clear_errors);
    end

    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign frame_error = frame_error_reg;
    assign overrun     = overrun_reg;
    assign busy        = (state_reg != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx with CLOCK_DIV=16, SYNC_STAGES=2.
// Received bytes are checked against a queue of expected bytes filled when
// each frame is sent; flags, busy and latency are compared explicitly.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DIV  = 16;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edges from driving the start bit to data_valid rising:
    // synchroniser + detect edge + half bit + data/parity/stop bits + delivery.
    localparam int LAT = SYNC + 1 + DIV / 2 + (9 + PAR_BITS) * DIV + 1;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       clear_errors;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLOCK_DIV   (DIV),
        .SYNC_STAGES (SYNC)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD  (1'b0)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .clear_errors (clear_errors),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pop one expected byte for each accepted handshake.
    always @(negedge clock) begin
        if (reset && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte actual=%02h expected=none (cycle %0d)", data_out, cyc);
            end else begin
                check("rx_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
        if (data_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = data_valid;
    end

    // Main thread always sits 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(DIV);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ^d;  // even parity
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_bit, output int c0);
        c0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_frame;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int c0;
        reset        = 1'b0;
        rx           = 1'b1;
        data_ready   = 1'b1;
        clear_errors = 1'b0;

        vecs[0] = '{data: 8'h55, stop_bit: 1'b1, exp_frame: 1'b0};
        vecs[1] = '{data: 8'h00, stop_bit: 1'b1, exp_frame: 1'b0};
        vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, exp_frame: 1'b0};
        vecs[3] = '{data: 8'h5A, stop_bit: 1'b0, exp_frame: 1'b1};
        vecs[4] = '{data: 8'hA5, stop_bit: 1'b1, exp_frame: 1'b0};

        // Reset state
        tick(5);
        check("rst_data_out", {24'd0, data_out}, 32'h0);
        check("rst_data_valid", {31'd0, data_valid}, 32'h0);
        check("rst_frame_error", {31'd0, frame_error}, 32'h0);
        check("rst_overrun", {31'd0, overrun}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        reset = 1'b1;
        tick(2 * DIV);

        // Table-driven frames with data_ready held high
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].stop_bit) exp_q.push_back(vecs[v].data);
            rise_cyc = -1;
            send_frame(vecs[v].data, vecs[v].stop_bit, good_par(vecs[v].data), c0);
            tick(2 * DIV);
            check("vec_frame_error", {31'd0, frame_error}, {31'd0, vecs[v].exp_frame});
            check("vec_overrun", {31'd0, overrun}, 32'h0);
            check("vec_busy", {31'd0, busy}, 32'h0);
            check("vec_valid_after", {31'd0, data_valid}, 32'h0);
            check("vec_queue_empty", exp_q.size(), 32'h0);
            if (vecs[v].stop_bit)
                check("vec_latency", rise_cyc, c0 + LAT);
            if (vecs[v].exp_frame) begin
                pulse_clear();
                check("vec_frame_cleared", {31'd0, frame_error}, 32'h0);
            end
        end

        // Overrun: two back-to-back frames while data_ready is low
        data_ready = 1'b0;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, good_par(8'hA3), c0);
        send_frame(8'h3C, 1'b1, good_par(8'h3C), c0);
        tick(2 * DIV);
        check("ovr_data_out", {24'd0, data_out}, 32'hA3);
        check("ovr_data_valid", {31'd0, data_valid}, 32'h1);
        check("ovr_overrun", {31'd0, overrun}, 32'h1);
        data_ready = 1'b1;
        tick(1);
        check("ovr_valid_cleared", {31'd0, data_valid}, 32'h0);
        check("ovr_overrun_sticky", {31'd0, overrun}, 32'h1);
        check("ovr_queue_empty", exp_q.size(), 32'h0);
        pulse_clear();
        check("ovr_overrun_cleared", {31'd0, overrun}, 32'h0);

        // Break: bad stop bit then line held low for 40 bit times
        send_frame(8'h81, 1'b0, good_par(8'h81), c0);
        rx = 1'b0;
        tick(40 * DIV);
        check("brk_frame_error", {31'd0, frame_error}, 32'h1);
        check("brk_busy", {31'd0, busy}, 32'h1);
        check("brk_data_valid", {31'd0, data_valid}, 32'h0);
        rx = 1'b1;
        tick(2 * DIV);
        check("brk_busy_released", {31'd0, busy}, 32'h0);
        pulse_clear();
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, good_par(8'h7E), c0);
        tick(2 * DIV);
        check("brk_after_queue_empty", exp_q.size(), 32'h0);
        check("brk_after_frame_error", {31'd0, frame_error}, 32'h0);

        // Glitch: 3-cycle low pulse in IDLE
        c0 = cyc;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(6 - 3);
        check("glitch_busy_mid", {31'd0, busy}, 32'h1);
        tick((c0 + SYNC + 1 + 9) - cyc);
        check("glitch_busy_done", {31'd0, busy}, 32'h0);
        check("glitch_frame_error", {31'd0, frame_error}, 32'h0);
        check("glitch_valid", {31'd0, data_valid}, 32'h0);
        tick(2 * DIV);

        // Reset in the middle of data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b0;
        tick(DIV / 2);
        reset = 1'b0;
        tick(1);
        check("mid_rst_data_out", {24'd0, data_out}, 32'h0);
        check("mid_rst_valid", {31'd0, data_valid}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        check("mid_rst_flags", {30'd0, frame_error, overrun}, 32'h0);
        reset = 1'b1;
        rx = 1'b1;
        tick(2 * DIV);
        exp_q.push_back(8'hC4);
        rise_cyc = -1;
        send_frame(8'hC4, 1'b1, good_par(8'hC4), c0);
        tick(2 * DIV);
        check("mid_rst_queue_empty", exp_q.size(), 32'h0);
        check("mid_rst_latency", rise_cyc, c0 + LAT);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has three ones, even parity bit is 1
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, c0);
        tick(2 * DIV);
        check("par_good_queue_empty", exp_q.size(), 32'h0);
        check("par_good_frame_error", {31'd0, frame_error}, 32'h0);
        send_frame(8'h07, 1'b1, 1'b0, c0);
        tick(2 * DIV);
        check("par_bad_frame_error", {31'd0, frame_error}, 32'h1);
        check("par_bad_valid", {31'd0, data_valid}, 32'h0);
        check("par_bad_busy", {31'd0, busy}, 32'h0);
        pulse_clear();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx
